// File: rtl/jogador_automatico.sv
`default_nettype none
// ----------------------------------------------------------------------------
// jogador_automatico : automatic player driving botoes for the sequence-memory game
// rev 1.0
// ----------------------------------------------------------------------------
module jogador_automatico #(
  parameter int         PRESS_CYC   = 10,
  parameter int         GAP_CYC     = 10,
  parameter int         MAX_JOGADAS = 16,
  parameter logic [3:0] SEED        = 4'b1001
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilitar,
  input  logic [3:0] leds,
  input  logic       pronto,
  input  logic       perdeu,
  output logic [3:0] botoes,
  output logic       ocupado,
  output logic       fim,
  output logic [4:0] jogadas,
  output logic [3:0] db_estado
);

  localparam int            CNT_MAX    = (PRESS_CYC > GAP_CYC) ? PRESS_CYC : GAP_CYC;
  localparam int            CW         = $clog2(CNT_MAX + 1);
  localparam logic [4:0]    MAX_J      = 5'(MAX_JOGADAS);
  localparam logic [CW-1:0] PRESS_LAST = CW'(PRESS_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);

  typedef enum logic [3:0] {
    INICIAL       = 4'd0,
    OBSERVA       = 4'd1,
    ESPERA_APAGAR = 4'd2,
    GAP           = 4'd3,
    PRESS_REP     = 4'd4,
    PRESS_NOVA    = 4'd5,
    FIM           = 4'd6
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [4:0]    k;
  logic [3:0]    lfsr;
  logic [3:0]    mem [16];
  logic          leds_onehot;
  logic          cnt_en;
  logic [3:0]    nova;

  assign leds_onehot = (leds != 4'd0) && ((leds & (leds - 4'd1)) == 4'd0);
  assign nova        = 4'b0001 << lfsr[1:0];
  assign cnt_en      = (state == GAP) || (state == PRESS_REP) || (state == PRESS_NOVA);
  assign db_estado   = state;

  // Priority: habilitar low beats an abort, which beats the normal flow.
  always_comb begin
    state_nxt = state;
    if (!habilitar) begin
      state_nxt = INICIAL;
    end else if ((state != INICIAL) && (pronto || perdeu)) begin
      state_nxt = FIM;
    end else begin
      case (state)
        INICIAL:       state_nxt = OBSERVA;
        OBSERVA:       if (leds_onehot) state_nxt = ESPERA_APAGAR;
        ESPERA_APAGAR: if (leds == 4'd0) state_nxt = GAP;
        GAP: begin
          if (cnt == GAP_LAST) begin
            if (k < jogadas)          state_nxt = PRESS_REP;
            else if (jogadas < MAX_J) state_nxt = PRESS_NOVA;
            else                      state_nxt = FIM;
          end
        end
        PRESS_REP, PRESS_NOVA: if (cnt == PRESS_LAST) state_nxt = GAP;
        FIM:           state_nxt = FIM;
        default:       state_nxt = INICIAL;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= INICIAL;
      botoes  <= 4'd0;
      ocupado <= 1'b0;
      fim     <= 1'b0;
      jogadas <= 5'd0;
      k       <= 5'd0;
      cnt     <= '0;
      lfsr    <= SEED;
    end else begin
      state   <= state_nxt;
      ocupado <= (state_nxt != INICIAL) && (state_nxt != FIM);
      fim     <= (state_nxt == FIM);

      if (state_nxt != state) cnt <= '0;
      else if (cnt_en)        cnt <= cnt + CW'(1);

      // Press value is loaded on the entering edge and dropped on any other state change.
      if ((state == GAP) && (state_nxt == PRESS_REP)) begin
        botoes <= mem[k[3:0]];
      end else if ((state == GAP) && (state_nxt == PRESS_NOVA)) begin
        botoes <= nova;
        lfsr   <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
      end else if (state_nxt != state) begin
        botoes <= 4'd0;
      end

      if (state_nxt == INICIAL) begin
        jogadas <= 5'd0;
        k       <= 5'd0;
      end else if ((state == OBSERVA) && (state_nxt == ESPERA_APAGAR)) begin
        jogadas <= 5'd1;
      end else if ((state == ESPERA_APAGAR) && (state_nxt == GAP)) begin
        k <= 5'd0;
      end else if ((state == PRESS_REP) && (state_nxt == GAP)) begin
        k <= k + 5'd1;
      end else if ((state == PRESS_NOVA) && (state_nxt == GAP)) begin
        jogadas <= jogadas + 5'd1;
        k       <= 5'd0;
      end
    end
  end

  // Sequence storage carries no reset; only entries below jogadas are ever read.
  always_ff @(posedge clock) begin
    if ((state == OBSERVA) && (state_nxt == ESPERA_APAGAR)) begin
      mem[0] <= leds;
    end else if ((state == GAP) && (state_nxt == PRESS_NOVA)) begin
      mem[jogadas[3:0]] <= nova;
    end
  end

endmodule
`default_nettype wire
